pipe_fetch: RTL and testbench

//   Instruction-fetch stage that feeds the IF/ID pipeline register. It owns the PC, issues

---
 rtl/pipe_fetch_pkg.sv | 20 ++
 rtl/pipe_fetch_if.sv | 32 +++
 rtl/pipe_fetch_ctr.sv | 23 ++
 rtl/pipe_fetch.sv | 142 ++++++++++++++
 tb/tb_pipe_fetch.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// the bubble instruction word, the PC increment and an alignment helper.
package pipe_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage : pipe_fetch_pkg

// File: rtl/pipe_fetch_if.sv
// Bundle of the fetch stage's pipeline-control, instruction-memory and
// IF/ID-facing signals. The master modport is the fetch stage itself; the
// slave modport is its environment (hazard unit, decode, memory).
interface pipe_fetch_if;

  // Pipeline control from hazard unit / decode
  logic        stall;
  logic        branch;
  logic [31:0] branch_target;

  // Instruction memory
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Towards the IF/ID register
  logic [31:0] inst;
  logic [31:0] pc4;
  logic        inst_valid;

  modport master (
    input  stall, branch, branch_target, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, inst, pc4, inst_valid
  );

  modport slave (
    output stall, branch, branch_target, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, inst, pc4, inst_valid
  );

endinterface : pipe_fetch_if

// File: rtl/pipe_fetch_ctr.sv
// 32-bit free-running event counter: counts cycles with inc=1, wraps at 2^32,
// never saturates. Asynchronous active-low reset clears it to zero.
module pipe_fetch_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;

  // Increment on every qualifying cycle; natural overflow provides the wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 32'h0;
    end else if (inc) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;

endmodule : pipe_fetch_ctr

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage. Owns the PC, keeps at most one request outstanding
// to instruction memory, and presents {pc4, inst} to the IF/ID register, or an
// all-zero bubble when nothing is ready. A fresh response is forwarded in the
// same cycle it arrives; if the pipeline is stalled it is parked in a hold
// buffer. A redirect while a request is still in flight goes through S_DROP
// so the orphaned response is swallowed instead of being presented.
// Optional feature macro: PIPE_FETCH_PERF_EN adds perf_fetched / perf_wait.
module pipe_fetch
  import pipe_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  pipe_fetch_if.master       bus
`ifdef PIPE_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_wait
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  hold_inst_q;
  logic [31:0]  hold_pc4_q;

  logic [31:0]  pc4_d;
  logic [31:0]  target_d;
  logic         redirect_d;

  assign pc4_d      = pc_q + PC_STEP;
  assign target_d   = word_align(bus.branch_target);
  // A stalled redirect is ignored; the hazard unit will present it again.
  assign redirect_d = bus.branch & ~bus.stall;

  // Output decode: request/address from state, IF/ID data from bypass or hold buffer.
  always_comb begin
    bus.imem_req   = 1'b0;
    bus.imem_addr  = 32'h0;
    bus.inst       = NOP_INST;
    bus.pc4        = 32'h0;
    bus.inst_valid = 1'b0;
    case (state_q)
      S_REQ: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = pc_q;
        if (bus.imem_rvalid) begin
          bus.inst       = bus.imem_rdata;
          bus.pc4        = pc4_d;
          bus.inst_valid = 1'b1;
        end
      end
      S_HOLD: begin
        bus.imem_addr  = pc_q;
        bus.inst       = hold_inst_q;
        bus.pc4        = hold_pc4_q;
        bus.inst_valid = 1'b1;
      end
      S_DROP: begin
        bus.imem_addr = pc_q;
      end
      default: ;
    endcase
  end

  // Fetch FSM with PC and hold buffer; redirect beats stall beats advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      hold_inst_q <= 32'h0;
      hold_pc4_q  <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Any stale response still arriving from before reset is ignored here.
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (redirect_d) begin
            pc_q    <= target_d;
            state_q <= bus.imem_rvalid ? S_REQ : S_DROP;
          end else if (bus.imem_rvalid) begin
            if (bus.stall) begin
              hold_inst_q <= bus.imem_rdata;
              hold_pc4_q  <= pc4_d;
              state_q     <= S_HOLD;
            end else begin
              pc_q <= pc4_d;
            end
          end
        end
        S_HOLD: begin
          if (redirect_d) begin
            pc_q    <= target_d;
            state_q <= S_REQ;
          end else if (!bus.stall) begin
            pc_q    <= pc4_d;
            state_q <= S_REQ;
          end
        end
        S_DROP: begin
          if (redirect_d) begin
            pc_q <= target_d;
          end
          // The orphan is done once it answers, even if a new redirect
          // lands in the same cycle; nothing else is in flight to wait for.
          if (bus.imem_rvalid) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PIPE_FETCH_PERF_EN
  // Index 0: consumed instructions, index 1: cycles waiting on memory.
  logic [1:0]  perf_inc;
  logic [31:0] perf_cnt [2];

  assign perf_inc[0] = ~bus.stall & ~bus.branch &
                       (((state_q == S_REQ) & bus.imem_rvalid) | (state_q == S_HOLD));
  assign perf_inc[1] = (state_q == S_REQ) & ~bus.imem_rvalid;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      pipe_fetch_ctr u_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (perf_inc[gi]),
        .count (perf_cnt[gi])
      );
    end
  endgenerate

  assign perf_fetched = perf_cnt[0];
  assign perf_wait    = perf_cnt[1];
`endif

endmodule : pipe_fetch

// File: tb/tb_pipe_fetch.sv
// Testbench for pipe_fetch. Stimulus pushes the expected {inst, pc4} for every
// cycle an instruction should be presented; an independent monitor pops and
// compares whenever inst_valid is seen, and checks the bubble is all-zero
// otherwise. Request/address are checked directly each stimulus cycle.
module tb_pipe_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [63:0] exp_q[$];

`ifdef PIPE_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_wait;
`endif

  pipe_fetch_if bus ();

  pipe_fetch #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef PIPE_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_wait    (perf_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [31:0] inst, input logic [31:0] pc4);
    exp_q.push_back({inst, pc4});
  endfunction

  // One stimulus cycle: drive inputs, check request/address mid-cycle, advance.
  task automatic tick(input string name, input logic st, input logic br,
                      input logic [31:0] tgt, input logic rv, input logic [31:0] rd,
                      input logic exp_req, input logic [31:0] exp_addr);
    bus.stall         = st;
    bus.branch        = br;
    bus.branch_target = tgt;
    bus.imem_rvalid   = rv;
    bus.imem_rdata    = rd;
    @(negedge clk);
    $display("[TB] %s: req=%0b addr=%h valid=%0b inst=%h pc4=%h",
             name, bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.pc4);
    chk32({name, " req"}, {31'b0, bus.imem_req}, {31'b0, exp_req});
    chk32({name, " addr"}, bus.imem_addr, exp_addr);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares presented instructions against the queue.
  always @(negedge clk) begin
    logic [63:0] e;
    if (bus.inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon unexpected: got inst %h pc4 %h, required no instruction",
                 bus.inst, bus.pc4);
      end else begin
        e = exp_q.pop_front();
        chk32("mon inst", bus.inst, e[63:32]);
        chk32("mon pc4", bus.pc4, e[31:0]);
      end
    end else begin
      chk32("mon bubble valid", {31'b0, bus.inst_valid}, 32'h0);
      chk32("mon bubble inst", bus.inst, 32'h0);
      chk32("mon bubble pc4", bus.pc4, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk32("reset req", {31'b0, bus.imem_req}, 32'h0);
      chk32("reset addr", bus.imem_addr, 32'h0);
      chk32("reset valid", {31'b0, bus.inst_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bus.stall = 0; bus.branch = 0; bus.branch_target = 0;
    bus.imem_rvalid = 0; bus.imem_rdata = 0;
    rst = 1'b1;
    #1;
    do_reset();

    // Idle cycle after release, then back-to-back fetches
    tick("idle",      0, 0, 32'h0, 0, 32'h0,         0, 32'h0);
    push_exp(32'h2008_0001, 32'h0040_0004);
    tick("fetch0",    0, 0, 32'h0, 1, 32'h2008_0001, 1, 32'h0040_0000);
    push_exp(32'h2009_0002, 32'h0040_0008);
    tick("fetch1",    0, 0, 32'h0, 1, 32'h2009_0002, 1, 32'h0040_0004);
    tick("wait0",     0, 0, 32'h0, 0, 32'h0,         1, 32'h0040_0008);

    // Stall while response arrives: held for capture + stalled + release cycles
    push_exp(32'h8C09_0000, 32'h0040_000C);
    tick("stall_cap", 1, 0, 32'h0, 1, 32'h8C09_0000, 1, 32'h0040_0008);
    push_exp(32'h8C09_0000, 32'h0040_000C);
    tick("stall_hld", 1, 0, 32'h0, 0, 32'h0,         0, 32'h0040_0008);
    push_exp(32'h8C09_0000, 32'h0040_000C);
    tick("stall_rel", 0, 0, 32'h0, 0, 32'h0,         0, 32'h0040_0008);

    // Redirect with request outstanding -> drop orphaned response
    tick("br_pend",   0, 1, 32'h0040_0100, 0, 32'h0, 1, 32'h0040_000C);
    tick("drop_wait", 0, 0, 32'h0, 0, 32'h0,         0, 32'h0040_0100);
    tick("drop_resp", 0, 0, 32'h0, 1, 32'hDEAD_BEEF, 0, 32'h0040_0100);

    // Redirect coinciding with a response; target low bits forced to zero
    push_exp(32'h1111_1111, 32'h0040_0104);
    tick("br_rvalid", 0, 1, 32'h0040_0203, 1, 32'h1111_1111, 1, 32'h0040_0100);
    tick("br_stall",  1, 1, 32'h0040_0300, 0, 32'h0, 1, 32'h0040_0200);
    push_exp(32'h2222_2222, 32'h0040_0204);
    tick("after_bst", 0, 0, 32'h0, 1, 32'h2222_2222, 1, 32'h0040_0200);
    tick("wait1",     0, 0, 32'h0, 0, 32'h0,         1, 32'h0040_0204);

    // PC wrap at the top of the address space
    tick("br_top",    0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0040_0204);
    tick("drop_top",  0, 0, 32'h0, 1, 32'h5555_5555, 0, 32'hFFFF_FFFC);
    push_exp(32'h3333_3333, 32'h0000_0000);
    tick("fetch_top", 0, 0, 32'h0, 1, 32'h3333_3333, 1, 32'hFFFF_FFFC);
    tick("wrapped",   0, 0, 32'h0, 0, 32'h0,         1, 32'h0000_0000);

    // Reset in the middle of an outstanding request
    rst = 1'b0;
    #1;
    chk32("midrst req", {31'b0, bus.imem_req}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick("stale_idle", 0, 0, 32'h0, 1, 32'h6666_6666, 0, 32'h0);
    push_exp(32'h4444_4444, 32'h0040_0004);
    tick("refetch",   0, 0, 32'h0, 1, 32'h4444_4444, 1, 32'h0040_0000);
    tick("wait2",     0, 0, 32'h0, 0, 32'h0,         1, 32'h0040_0004);

`ifdef PIPE_FETCH_PERF_EN
    do_reset();
    tick("perf_idle", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++)
      tick("perf_wait", 0, 0, 32'h0, 0, 32'h0, 1, RST_PC);
    for (int i = 0; i < 5; i++) begin
      push_exp(32'h7000_0000 + 32'(i), RST_PC + 32'(4 * (i + 1)));
      tick("perf_fetch", 0, 0, 32'h0, 1, 32'h7000_0000 + 32'(i), 1, RST_PC + 32'(4 * i));
    end
    bus.imem_rvalid = 1'b0;
    @(negedge clk);
    chk32("perf_wait", perf_wait, 32'd3);
    chk32("perf_fetched", perf_fetched, 32'd5);
    @(posedge clk);
    #1;
`endif

    bus.imem_rvalid = 1'b0;
    @(negedge clk);
    chk32("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_fetch
